// File: rtl/pong_pkg.sv
// Shared playfield geometry, scoring limits and game-state encoding for the pong engine.
package pong_pkg;

  localparam int FIELD_W   = 64;
  localparam int FIELD_H   = 32;
  localparam int CENTER_X  = 32;
  localparam int CENTER_Y  = 16;
  localparam int WIN_SCORE = 7;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    POINT,
    OVER
  } gameState_t;

  // Scores stop at the winning value instead of wrapping.
  function automatic logic [3:0] satInc(input logic [3:0] score);
    return (score >= 4'(WIN_SCORE)) ? score : score + 4'd1;
  endfunction

endpackage

// File: rtl/ball_engine.sv
// Ball motion, paddle collision, scoring and game-state sequencing for a 64x32 pong field.
module ball_engine
  import pong_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        serve,
  input  logic [31:0] left_paddle,
  input  logic [31:0] right_paddle,
  output logic [5:0]  ball_x,
  output logic [4:0]  ball_y,
  output logic        point_left,
  output logic        point_right,
  output logic [3:0]  left_score,
  output logic [3:0]  right_score,
  output logic        game_over
);

  gameState_t state;
  logic       dxPos;
  logic       dyPos;
  logic       lastScorerLeft;

  logic [5:0] xNext;
  logic [4:0] yNext;
  logic       dxPosNext;
  logic       dyPosNext;
  logic       missLeft;
  logic       missRight;
  logic [3:0] scorerScore;

  // One-tick motion step; the paddle test looks at the row the ball occupies before it moves.
  always_comb begin
    yNext     = ball_y;
    dyPosNext = dyPos;
    xNext     = ball_x;
    dxPosNext = dxPos;
    missLeft  = 1'b0;
    missRight = 1'b0;

    if (dyPos) begin
      if (ball_y == 5'(FIELD_H - 1)) begin
        yNext     = 5'(FIELD_H - 2);
        dyPosNext = 1'b0;
      end else begin
        yNext = ball_y + 5'd1;
      end
    end else begin
      if (ball_y == 5'd0) begin
        yNext     = 5'd1;
        dyPosNext = 1'b1;
      end else begin
        yNext = ball_y - 5'd1;
      end
    end

    if (!dxPos && ball_x == 6'd1) begin
      if (left_paddle[ball_y]) begin
        xNext     = 6'd2;
        dxPosNext = 1'b1;
      end else begin
        xNext    = 6'd0;
        missLeft = 1'b1;
      end
    end else if (dxPos && ball_x == 6'(FIELD_W - 2)) begin
      if (right_paddle[ball_y]) begin
        xNext     = 6'(FIELD_W - 3);
        dxPosNext = 1'b0;
      end else begin
        xNext     = 6'(FIELD_W - 1);
        missRight = 1'b1;
      end
    end else if (dxPos) begin
      xNext = ball_x + 6'd1;
    end else begin
      xNext = ball_x - 6'd1;
    end

    scorerScore = lastScorerLeft ? left_score : right_score;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      ball_x         <= 6'(CENTER_X);
      ball_y         <= 5'(CENTER_Y);
      dxPos          <= 1'b1;
      dyPos          <= 1'b1;
      lastScorerLeft <= 1'b0;
      left_score     <= 4'd0;
      right_score    <= 4'd0;
      point_left     <= 1'b0;
      point_right    <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      point_left  <= 1'b0;
      point_right <= 1'b0;
      case (state)
        IDLE: begin
          ball_x <= 6'(CENTER_X);
          ball_y <= 5'(CENTER_Y);
          if (serve) state <= PLAY;
        end
        PLAY: begin
          if (tick) begin
            ball_x <= xNext;
            ball_y <= yNext;
            dxPos  <= dxPosNext;
            dyPos  <= dyPosNext;
            if (missLeft) begin
              state          <= POINT;
              point_right    <= 1'b1;
              right_score    <= satInc(right_score);
              lastScorerLeft <= 1'b0;
            end else if (missRight) begin
              state          <= POINT;
              point_left     <= 1'b1;
              left_score     <= satInc(left_score);
              lastScorerLeft <= 1'b1;
            end
          end
        end
        POINT: begin
          // Re-serve heads toward whoever just conceded.
          if (tick) begin
            ball_x <= 6'(CENTER_X);
            ball_y <= 5'(CENTER_Y);
            dyPos  <= 1'b1;
            dxPos  <= lastScorerLeft;
            if (scorerScore == 4'(WIN_SCORE)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        OVER: begin
          ball_x    <= 6'(CENTER_X);
          ball_y    <= 5'(CENTER_Y);
          game_over <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Randomised bench for ball_engine against a behavioural game model, plus a few directed scenarios.
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        serve;
  logic [31:0] left_paddle;
  logic [31:0] right_paddle;
  logic [5:0]  ball_x;
  logic [4:0]  ball_y;
  logic        point_left;
  logic        point_right;
  logic [3:0]  left_score;
  logic [3:0]  right_score;
  logic        game_over;

  int checkCount = 0;
  int failCount  = 0;
  int overSeen   = 0;

  // Reference model state kept as plain integers.
  int mMode;
  int mx, my, mdx, mdy;
  int mLeft, mRight;
  int mPl, mPr;
  bit mScorerLeft;

  localparam int M_IDLE = 0, M_PLAY = 1, M_POINT = 2, M_OVER = 3;

  ball_engine dut (
    .clk(clk), .reset(reset), .tick(tick), .serve(serve),
    .left_paddle(left_paddle), .right_paddle(right_paddle),
    .ball_x(ball_x), .ball_y(ball_y),
    .point_left(point_left), .point_right(point_right),
    .left_score(left_score), .right_score(right_score),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mx = 32; my = 16; mdx = 1; mdy = 1;
    mLeft = 0; mRight = 0; mPl = 0; mPr = 0; mScorerLeft = 0;
  endtask

  task automatic modelStep(input bit rst, input bit tk, input bit sv, input logic [31:0] lp, input logic [31:0] rp);
    int ny;
    mPl = 0; mPr = 0;
    if (!rst) begin
      modelReset();
      return;
    end
    case (mMode)
      M_IDLE: begin
        mx = 32; my = 16;
        if (sv) mMode = M_PLAY;
      end
      M_PLAY: if (tk) begin
        if (mdy == 1 && my == 31) begin ny = 30; mdy = -1; end
        else if (mdy == -1 && my == 0) begin ny = 1; mdy = 1; end
        else ny = my + mdy;
        if (mdx == -1 && mx == 1) begin
          if (lp[my]) begin mx = 2; mdx = 1; end
          else begin
            mx = 0; mPr = 1; mMode = M_POINT; mScorerLeft = 0;
            mRight = (mRight < 7) ? mRight + 1 : 7;
          end
        end else if (mdx == 1 && mx == 62) begin
          if (rp[my]) begin mx = 61; mdx = -1; end
          else begin
            mx = 63; mPl = 1; mMode = M_POINT; mScorerLeft = 1;
            mLeft = (mLeft < 7) ? mLeft + 1 : 7;
          end
        end else begin
          mx = mx + mdx;
        end
        my = ny;
      end
      M_POINT: if (tk) begin
        mx = 32; my = 16; mdy = 1;
        mdx = mScorerLeft ? 1 : -1;
        mMode = ((mScorerLeft ? mLeft : mRight) == 7) ? M_OVER : M_IDLE;
      end
      default: begin
        mx = 32; my = 16;
      end
    endcase
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
  task automatic applyStimulus(input bit rst, input bit tk, input bit sv, input logic [31:0] lp, input logic [31:0] rp);
    reset = rst; tick = tk; serve = sv; left_paddle = lp; right_paddle = rp;
    @(posedge clk);
    modelStep(rst, tk, sv, lp, rp);
    @(negedge clk);
    checkOutput("ball_x", 32'(ball_x), 32'(mx));
    checkOutput("ball_y", 32'(ball_y), 32'(my));
    checkOutput("point_left", 32'(point_left), 32'(mPl));
    checkOutput("point_right", 32'(point_right), 32'(mPr));
    checkOutput("left_score", 32'(left_score), 32'(mLeft));
    checkOutput("right_score", 32'(right_score), 32'(mRight));
    checkOutput("game_over", 32'(game_over), 32'(mMode == M_OVER));
    if (mMode == M_OVER) overSeen++;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; serve = 1'b0; left_paddle = '0; right_paddle = '0;
    modelReset();
    @(negedge clk);

    applyStimulus(0, 1, 1, '1, '1);
    checkOutput("reset_x", 32'(ball_x), 32'd32);
    checkOutput("reset_y", 32'(ball_y), 32'd16);
    checkOutput("reset_over", 32'(game_over), 32'd0);

    // Serve for one cycle then three ticks from centre.
    applyStimulus(1, 0, 1, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0, '0);
    checkOutput("serve3_x", 32'(ball_x), 32'd35);
    checkOutput("serve3_y", 32'(ball_y), 32'd19);
    checkOutput("serve3_pts", 32'({point_left, point_right}), 32'd0);

    // Reset wins over a simultaneous tick mid-rally.
    applyStimulus(0, 1, 0, '0, '0);
    checkOutput("midreset_x", 32'(ball_x), 32'd32);
    checkOutput("midreset_y", 32'(ball_y), 32'd16);
    checkOutput("midreset_pts", 32'({point_left, point_right}), 32'd0);

    for (int i = 0; i < 30000; i++) begin
      applyStimulus($urandom_range(0, 1499) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom & $urandom,
                    $urandom & $urandom);
    end

    checkOutput("reached_over", 32'(overSeen > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
